// File: rtl/dpll_pilot_gen2.sv
// ---------------------------------------------------------------------------
// dpll_pilot_gen2
//   Second-generation digital PLL. Locks an NCO to a 1-bit pilot (for example
//   the 19 kHz stereo pilot) that is sampled on a clock-enable strobe. The
//   output is phase coherent with the input at f_in * 2^mult_sel / 2^div_sel.
//   It is provided as a signed triangle wave and as a square wave.
//   Loop features: a PI loop filter, lock detection, a loss-of-signal timeout,
//   and holdover (either manual or automatic on loss).
//
// Ports
//   CLK        in   1      system clock
//   RSTb       in   1      asynchronous active-low reset
//   ce         in   1      sample strobe; all loop state advances only on ce
//   xin        in   1      1-bit pilot input, sampled on ce
//   mult_sel   in   3      output multiply by 2^mult_sel (taken on ce)
//   div_sel    in   3      output divide by 2^div_sel (taken on ce)
//   hold       in   1      freeze integrator and corrections, free-run the NCO
//   sigout     out  OUT_W  signed triangle of output phase (registered)
//   digout     out  1      square output, 1 in first half of each cycle
//   locked     out  1      lock indicator (registered)
//   freq_word  out  ACC_W  current tuning word NOM_FREQ + integrator
// ---------------------------------------------------------------------------
module dpll_pilot_gen2 #(
    parameter int               ACC_W    = 32,
    parameter int               OUT_W    = 16,
    parameter logic [ACC_W-1:0] NOM_FREQ = ACC_W'(163208757),
    parameter int               KP_SHIFT = 4,
    parameter int               KI_SHIFT = 10,
    parameter int               LOCK_TOL = 2048,
    parameter int               LOCK_CNT = 32,
    parameter int               LOSS_TO  = 256
) (
    input  logic                    CLK,
    input  logic                    RSTb,
    input  logic                    ce,
    input  logic                    xin,
    input  logic [2:0]              mult_sel,
    input  logic [2:0]              div_sel,
    input  logic                    hold,
    output logic signed [OUT_W-1:0] sigout,
    output logic                    digout,
    output logic                    locked,
    output logic [ACC_W-1:0]        freq_word
);

    // Signed working width: wide enough for acc_ext steps plus a sign bit.
    localparam int SW  = ACC_W + 8;
    localparam int EW  = ACC_W + 7;
    localparam int LCW = $clog2(LOCK_CNT + 1);
    localparam int LSW = $clog2(LOSS_TO + 1);

    localparam logic signed [SW-1:0] C_NOM      = $signed({{(SW-ACC_W){1'b0}}, NOM_FREQ});
    localparam logic signed [SW-1:0] C_LIM      = C_NOM >>> 2;
    localparam logic signed [SW-1:0] C_LIM_N    = -C_LIM;
    localparam logic [OUT_W:0]       C_TOL      = (OUT_W+1)'(LOCK_TOL);
    localparam logic [LCW-1:0]       C_LOCK_MAX = LCW'(LOCK_CNT);
    localparam logic [LSW-1:0]       C_LOSS_MAX = LSW'(LOSS_TO);
    localparam logic [LSW-1:0]       C_LOSS_PRE = LSW'(LOSS_TO - 1);

    logic [EW-1:0]           r_acc_ext;
    logic signed [SW-1:0]    r_integ;
    logic                    r_xin_d;
    logic [LCW-1:0]          r_lock_cnt;
    logic [LSW-1:0]          r_loss_cnt;
    logic [2:0]              r_mult_sel;
    logic [2:0]              r_div_sel;
    logic signed [OUT_W-1:0] r_sigout;
    logic                    r_digout;
    logic                    r_locked;
    logic [ACC_W-1:0]        r_freq_word;

    logic                    w_edge;
    logic [OUT_W-1:0]        w_err_bits;
    logic [OUT_W-1:0]        w_err_mag;
    logic                    w_in_window;
    logic signed [SW-1:0]    w_err_ext;
    logic signed [SW-1:0]    w_kp;
    logic signed [SW-1:0]    w_ki;
    logic signed [SW-1:0]    w_integ_raw;
    logic signed [SW-1:0]    w_integ_new;
    logic                    w_loss_hit;
    logic [OUT_W:0]          w_tri_src;
    logic [OUT_W-1:0]        w_tri_u;

    assign w_edge = xin & ~r_xin_d;

    // The NCO phase at the edge is the phase error: positive means NCO early.
    assign w_err_bits  = r_acc_ext[ACC_W-1 -: OUT_W];
    assign w_err_mag   = w_err_bits[OUT_W-1] ? (~w_err_bits + OUT_W'(1)) : w_err_bits;
    assign w_in_window = ({1'b0, w_err_mag} < C_TOL);
    assign w_err_ext   = {{(SW-OUT_W){w_err_bits[OUT_W-1]}}, w_err_bits} <<< (ACC_W - OUT_W);
    assign w_kp        = w_err_ext >>> KP_SHIFT;
    assign w_ki        = w_err_ext >>> KI_SHIFT;
    assign w_integ_raw = r_integ - w_ki;

    // The integrator saturates at +/- NOM/4 instead of wrapping.
    always_comb begin
        w_integ_new = w_integ_raw;
        if (w_integ_raw > C_LIM)
            w_integ_new = C_LIM;
        else if (w_integ_raw < C_LIM_N)
            w_integ_new = C_LIM_N;
    end

    // Loss fires on the non-edge ce that brings loss_cnt to LOSS_TO, and keeps firing while saturated.
    assign w_loss_hit = ~w_edge & (r_loss_cnt >= C_LOSS_PRE);

    // Output phase: the top 7 cycle-count bits of acc_ext feed the divider.
    // Only the top OUT_W+1 bits of the ACC_W-bit output phase are kept.
    assign w_tri_src = (OUT_W+1)'(((r_acc_ext >> r_div_sel) << r_mult_sel) >> (ACC_W - OUT_W - 1));
    // Second half of the cycle mirrors the first, so the triangle falls back.
    assign w_tri_u   = w_tri_src[OUT_W] ? ~w_tri_src[OUT_W-1:0] : w_tri_src[OUT_W-1:0];

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_acc_ext   <= '0;
            r_integ     <= '0;
            r_xin_d     <= 1'b0;
            r_lock_cnt  <= '0;
            r_loss_cnt  <= '0;
            r_mult_sel  <= '0;
            r_div_sel   <= '0;
            r_sigout    <= '0;
            r_digout    <= 1'b0;
            r_locked    <= 1'b0;
            r_freq_word <= NOM_FREQ;
        end else begin
            r_freq_word <= NOM_FREQ + r_integ[ACC_W-1:0];
            r_locked    <= (r_lock_cnt == C_LOCK_MAX);
            r_digout    <= ~w_tri_src[OUT_W];
            r_sigout    <= {~w_tri_u[OUT_W-1], w_tri_u[OUT_W-2:0]};
            if (ce) begin
                r_xin_d    <= xin;
                r_mult_sel <= mult_sel;
                r_div_sel  <= div_sel;

                if (w_edge && !hold) begin
                    r_integ   <= w_integ_new;
                    // Proportional term is a one-shot phase nudge, not a frequency change.
                    r_acc_ext <= r_acc_ext + EW'(C_NOM + w_integ_new - w_kp);
                end else begin
                    r_acc_ext <= r_acc_ext + EW'(C_NOM + r_integ);
                end

                if (w_edge) begin
                    r_loss_cnt <= '0;
                    if (!w_in_window)
                        r_lock_cnt <= '0;
                    else if (r_lock_cnt != C_LOCK_MAX)
                        r_lock_cnt <= r_lock_cnt + LCW'(1);
                end else begin
                    if (r_loss_cnt != C_LOSS_MAX)
                        r_loss_cnt <= r_loss_cnt + LSW'(1);
                    if (w_loss_hit)
                        r_lock_cnt <= '0;
                end
            end
        end
    end

    assign sigout    = r_sigout;
    assign digout    = r_digout;
    assign locked    = r_locked;
    assign freq_word = r_freq_word;

endmodule

// File: tb/tb_dpll_pilot_gen2.sv
// ---------------------------------------------------------------------------
// tb_dpll_pilot_gen2
//   Randomised bench for dpll_pilot_gen2 with a cycle-count reference model.
//   The model keeps the NCO phase as a plain integer count of 2^-32 cycles.
// ---------------------------------------------------------------------------
module tb_dpll_pilot_gen2;

    localparam longint NOM   = 163208757;
    localparam longint LIM   = NOM / 4;
    localparam longint TWO32 = 64'h1_0000_0000;
    localparam longint MOD39 = 64'h80_0000_0000;

    logic        CLK = 1'b0;
    logic        RSTb;
    logic        ce;
    logic        xin;
    logic [2:0]  mult_sel;
    logic [2:0]  div_sel;
    logic        hold;
    logic [15:0] sigout;
    logic        digout;
    logic        locked;
    logic [31:0] freq_word;

    int n_checks = 0;
    int n_errors = 0;

    dpll_pilot_gen2 dut (
        .CLK       (CLK),
        .RSTb      (RSTb),
        .ce        (ce),
        .xin       (xin),
        .mult_sel  (mult_sel),
        .div_sel   (div_sel),
        .hold      (hold),
        .sigout    (sigout),
        .digout    (digout),
        .locked    (locked),
        .freq_word (freq_word)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    longint m_acc;     // phase in 2^-32 cycles, modulo 128 input cycles
    longint m_integ;   // frequency offset from NOM
    bit     m_xd;
    int     m_lock;    // consecutive in-window edges
    int     m_loss;    // ce since last rising edge
    int     m_mult;
    int     m_div;

    bit [31:0] gen_ph;
    int        mult_v;
    int        div_v;

    task automatic model_reset();
        m_acc = 0; m_integ = 0; m_xd = 0; m_lock = 0; m_loss = 0;
        m_mult = 0; m_div = 0;
    endtask

    function automatic longint wrap39(input longint v);
        return ((v % MOD39) + MOD39) % MOD39;
    endfunction

    task automatic model_ce(input bit x, input bit h, input int ms, input int ds);
        longint frac;
        longint err;
        longint inew;
        bit     rise;
        rise = x && !m_xd;
        // Phase within the current cycle, folded into [-0.5, 0.5) in 2^-16 units.
        frac = m_acc % TWO32;
        err  = frac / 65536;
        if (err >= 32768) err = err - 65536;
        if (rise) begin
            m_loss = 0;
            if (err < 2048 && err > -2048) m_lock = (m_lock < 32) ? m_lock + 1 : 32;
            else m_lock = 0;
        end else begin
            if (m_loss < 256) m_loss = m_loss + 1;
            if (m_loss == 256) m_lock = 0;
        end
        if (rise && !h) begin
            // Integrator step is err/1024 of a cycle, proportional nudge err/16.
            inew = m_integ - err * 64;
            if (inew > LIM) inew = LIM;
            if (inew < -LIM) inew = -LIM;
            m_integ = inew;
            m_acc = wrap39(m_acc + NOM + m_integ - err * 4096);
        end else begin
            m_acc = wrap39(m_acc + NOM + m_integ);
        end
        m_xd = x; m_mult = ms; m_div = ds;
    endtask

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string phase);
        longint oph;
        int     t;
        int     s;
        logic [15:0] e16;
        oph = ((m_acc / (64'd1 << m_div)) * (64'd1 << m_mult)) % TWO32;
        t   = int'(oph / 32768);
        if (t < 65536) s = t - 32768;
        else           s = 131071 - t - 32768;
        e16 = s[15:0];
        check_eq({phase, ".sigout"},    64'(sigout),    64'(e16));
        check_eq({phase, ".digout"},    64'(digout),    64'(oph < 64'h8000_0000));
        check_eq({phase, ".locked"},    64'(locked),    64'(m_lock == 32));
        check_eq({phase, ".freq_word"}, 64'(freq_word), 64'((NOM + m_integ) % TWO32));
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, ".sigout"},    64'(sigout),    64'd0);
        check_eq({tag, ".digout"},    64'(digout),    64'd0);
        check_eq({tag, ".locked"},    64'(locked),    64'd0);
        check_eq({tag, ".freq_word"}, 64'(freq_word), 64'(NOM));
    endtask

    // ---------------- drivers ----------------
    // One ce pulse, then one idle CLK so the registered outputs settle.
    task automatic do_ce(input bit x, input bit h, input string phase);
        @(negedge CLK);
        xin = x; hold = h; mult_sel = 3'(mult_v); div_sel = 3'(div_v); ce = 1'b1;
        @(negedge CLK);
        ce = 1'b0;
        @(negedge CLK);
        model_ce(x, h, mult_v, div_v);
        check_outputs(phase);
    endtask

    // mode 0: square at 'word', 1: xin held low, 2: random bits
    task automatic run_ces(input int n, input int unsigned word, input bit h,
                           input int mode, input bit sel_rand, input string phase);
        bit x;
        for (int i = 0; i < n; i++) begin
            if (sel_rand && (i % 400 == 399)) begin
                mult_v = $urandom_range(0, 7);
                div_v  = $urandom_range(0, 7);
            end
            gen_ph = gen_ph + word;
            case (mode)
                0:       x = gen_ph[31];
                1:       x = 1'b0;
                default: x = 1'($urandom_range(0, 1));
            endcase
            do_ce(x, h, phase);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int unsigned w;
        RSTb = 1'b0; ce = 1'b0; xin = 1'b0; hold = 1'b0;
        mult_sel = 3'd0; div_sel = 3'd0;
        mult_v = 1; div_v = 0;
        gen_ph = 32'($urandom);
        model_reset();
        #12;
        check_reset_vals("por");
        repeat (3) @(negedge CLK);
        RSTb = 1'b1;

        // Acquisition near 19 kHz with the selects changing on the fly.
        w = 32'(NOM) + $urandom_range(0, 200000) - 100000;
        run_ces(4000, w, 1'b0, 0, 1'b1, "acq");

        // Frequency step to 19.1 kHz.
        run_ces(2500, 32'd164067750, 1'b0, 0, 1'b0, "f191");

        // Loss of signal, then recovery at nominal.
        run_ces(400, 32'(NOM), 1'b0, 1, 1'b0, "loss");
        run_ces(3000, 32'(NOM), 1'b0, 0, 1'b0, "relock");

        // Holdover while the input steps to 19.5 kHz, then release.
        run_ces(1500, 32'd167503725, 1'b1, 0, 1'b0, "hold");
        run_ces(2000, 32'd167503725, 1'b0, 0, 1'b1, "release");

        // Random bit noise exercises the integrator clamp and window edges.
        run_ces(300, 32'(NOM), 1'b0, 2, 1'b0, "noise");

        // ce held low: nothing may move.
        repeat (20) @(negedge CLK);
        check_outputs("idle");

        // Asynchronous reset mid-run, sampled before any CLK edge.
        @(negedge CLK);
        #2 RSTb = 1'b0;
        #1 check_reset_vals("async_rst");
        model_reset();
        repeat (3) @(negedge CLK);
        RSTb = 1'b1;
        mult_v = 0; div_v = 3;
        run_ces(500, 32'(NOM), 1'b0, 0, 1'b0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
